// File: rtl/div_if.sv
// Issue/writeback bundle between the issuing pipeline stage and the divider.
// The master issues divides; the slave (the divider) raises stall and presents HI/LO writes.
interface div_if;
    logic        div_start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        stall_o;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        busy;

    modport master (
        output div_start, div_signed, dividend, divisor, cancel,
        input  stall_o, hi_we, lo_we, hi_wdata, lo_wdata, busy
    );

    modport slave (
        input  div_start, div_signed, dividend, divisor, cancel,
        output stall_o, hi_we, lo_we, hi_wdata, lo_wdata, busy
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle 32-bit integer divider (DIV/DIVU): restoring shift-subtract on magnitudes,
// one quotient bit per cycle, with results written to HI (remainder) and LO (quotient).
module div_unit (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  dif
);
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        BUSY    = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e              state_q;
    logic [4:0]          cnt_q;
    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   quo_q;
    logic [DATA_W-1:0]   dvs_q;
    logic                qneg_q;
    logic                rneg_q;
    logic                we_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;

    logic [DATA_W:0]     rem_sh;
    logic [DATA_W:0]     rem_sub;
    logic [DATA_W-1:0]   rem_d;
    logic [DATA_W-1:0]   quo_d;
    logic                a_neg;
    logic                b_neg;

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign a_neg = dif.div_signed & dif.dividend[DATA_W-1];
    assign b_neg = dif.div_signed & dif.divisor[DATA_W-1];

    // One restoring step: the quotient register doubles as the dividend shifter.
    always_comb begin
        rem_sh  = {rem_q, quo_q[DATA_W-1]};
        rem_sub = rem_sh - {1'b0, dvs_q};
        if (rem_sh >= {1'b0, dvs_q}) begin
            rem_d = rem_sub[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
            rem_d = rem_sh[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            we_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            we_q <= 1'b0;
            hi_q <= '0;
            lo_q <= '0;
            case (state_q)
                IDLE: begin
                    if (dif.div_start && !dif.cancel) begin
                        if (dif.divisor == '0) begin
                            state_q <= DIVZERO;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= '0;
                            rem_q   <= '0;
                            quo_q   <= cond_neg(dif.dividend, a_neg);
                            dvs_q   <= cond_neg(dif.divisor, b_neg);
                            qneg_q  <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
                        end
                    end
                end
                DIVZERO: begin
                    if (dif.cancel) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= DONE;
                        we_q    <= 1'b1;
                    end
                end
                BUSY: begin
                    if (dif.cancel) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 5'd1;
                        // Last bit: sign-correct the magnitudes straight into the write registers.
                        if (cnt_q == 5'd31) begin
                            state_q <= DONE;
                            we_q    <= 1'b1;
                            lo_q    <= cond_neg(quo_d, qneg_q);
                            hi_q    <= cond_neg(rem_d, rneg_q);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dif.hi_we    = we_q;
    assign dif.lo_we    = we_q;
    assign dif.hi_wdata = hi_q;
    assign dif.lo_wdata = lo_q;
    assign dif.busy     = (state_q != IDLE);
    // rst gates the combinational start term so stall drops the instant reset is applied.
    assign dif.stall_o  = ~rst & (((state_q == IDLE) & dif.div_start & ~dif.cancel) |
                                  (state_q == BUSY) | (state_q == DIVZERO));
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The module SHALL have these ports, clock and reset first:
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- div_start  input  1  request a division; sampled only in IDLE.
- div_signed  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with div_start.
- dividend  input  32  operand A; sampled with div_start.
- divisor  input  32  operand B; sampled with div_start.
- cancel  input  1  pipeline flush; aborts the operation in flight.
- stall_o  output  1  hold the issuing pipeline stage.
- hi_we  output  1  HI write enable toward the HI/LO register file.
- lo_we  output  1  LO write enable toward the HI/LO register file.
- hi_wdata  output  32  remainder, written to HI.
- lo_wdata  output  32  quotient, written to LO.
- busy  output  1  high in any state other than IDLE.
REQ-002 Reset SHALL be asynchronous and active-high on rst; clk is the only clock.

Function
REQ-003 The FSM SHALL have four states: IDLE, DIVZERO, BUSY, DONE.
REQ-004 IDLE, div_start=1, divisor!=0 -> BUSY; operands and div_signed latched; iteration counter cleared.
REQ-005 IDLE, div_start=1, divisor==0 -> DIVZERO; DIVZERO -> DONE on the next edge, with quotient=0 and remainder=0.
REQ-006 BUSY SHALL run restoring shift-subtract on 32-bit absolute values: exactly one quotient bit per cycle for 32 cycles, then -> DONE.
REQ-007 DONE -> IDLE unconditionally on the next edge.
REQ-008 Latency: call the cycle with div_start high in IDLE cycle 0. BUSY occupies cycles 1-32, DONE is cycle 33, and IDLE returns in cycle 34. For the divide-by-zero case, DIVZERO is cycle 1 and DONE is cycle 2.
REQ-009 hi_we and lo_we SHALL both be 1 only while the state is DONE; they are 0 in every other state.
REQ-010 hi_wdata and lo_wdata SHALL hold the final results while in DONE and are 0 in every other state.
REQ-011 stall_o SHALL equal (IDLE & div_start & ~cancel) | BUSY | DIVZERO; it is 0 in DONE, so the issuing stage advances in the same cycle the write occurs.
REQ-012 Signed mode result signs:
- Quotient sign = sign(dividend) XOR sign(divisor).
- Remainder takes the sign of the dividend.
- Negation is 32-bit two's complement.
REQ-013 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-014 Unsigned mode SHALL treat all 32 bits as magnitude.
REQ-015 div_start outside IDLE SHALL be ignored; no queuing occurs.
REQ-016 cancel=1 in BUSY or DIVZERO -> IDLE on the next edge, with no hi_we/lo_we pulse.
REQ-017 cancel=1 together with div_start in IDLE SHALL suppress the start.
REQ-018 cancel=1 in DONE SHALL NOT suppress the write already being presented.
REQ-019 Operands changing after the cycle-0 sample SHALL NOT affect the result.

Reset
REQ-020 rst=1 SHALL immediately force state IDLE, counter 0, and all latched operands 0, without waiting for a clock edge.
REQ-021 While rst is high, and after reset, all outputs SHALL be 0: stall_o, busy, hi_we, lo_we, hi_wdata, lo_wdata.
REQ-022 Reset asserted during BUSY SHALL abort the operation with no write pulse.
REQ-023 The first div_start accepted after rst deasserts SHALL behave per REQ-008.

Verification
REQ-024 Unsigned 100 / 7 -> DONE in cycle 33, lo_wdata=14, hi_wdata=2, hi_we=lo_we=1 for exactly one cycle.
REQ-025 Signed -7 (0xFFFFFFF9) / 2 -> lo_wdata=0xFFFFFFFD, hi_wdata=0xFFFFFFFF; unsigned 0xFFFFFFF9 / 2 -> lo_wdata=0x7FFFFFFC, hi_wdata=1.
REQ-026 Divisor 0, dividend 0x1234 -> DONE in cycle 2 with hi_wdata=lo_wdata=0; stall_o high in cycles 0-1 only.
REQ-027 Signed 0x80000000 / 0xFFFFFFFF -> lo_wdata=0x80000000, hi_wdata=0.
REQ-028 cancel pulsed in cycle 10 of a BUSY run -> IDLE in cycle 11, no write enables; a new div_start in cycle 12 is accepted normally.
REQ-029 rst asserted mid-clock in cycle 20 -> busy and stall_o drop without a clock edge; no write pulse; a new divide started after reset completes correctly.
